// File: rtl/joybus_frame_sniffer.sv
// ---------------------------------------------------------------------------
// joybus_frame_sniffer
//
// Passive decoder for the N64 controller port line. It recovers bits from the
// low/high interval of each Joybus bit cell, decodes the command byte and then
// the number of payload/response bytes given by a per-command length table.
// Every complete frame is presented on a held output register with a
// valid/ack handshake. Frames that complete while an earlier one is still
// held are counted as drops.
//
// Optional feature macro:
//   JOYBUS_GAMEID_EN  adds command 0x1D (game ID, 10 bytes) to the length
//                     table; requires MAX_BYTES >= 10.
//
// Parameters:
//   CNT_W            width of the edge-interval counter; saturation = idle
//   VIRT_NEGEDGE_TH  cycles after a rising edge at which a virtual falling
//                    edge samples the bit (ends the last bit of a frame)
//   MAX_BYTES        frame data buffer capacity in bytes (3..16)
//
// Ports:
//   CTRL_CLK         sampling clock
//   CTRL_RST         synchronous active-high reset
//   CTRL_i           raw Joybus line (asynchronous)
//   frame_ack_i      consumer acknowledge (pulse or level)
//   frame_valid_o    a held frame is available
//   frame_cmd_o      command byte of the held frame
//   frame_len_o      number of data bytes in the held frame
//   frame_data_o     data bytes; byte k at [8k+7:8k], MSB first on the wire
//   frame_err_o      one-cycle pulse on a stop-bit failure
//   drop_cnt_o       saturating count of frames lost while valid was high
//   ctrl_detected_o  a controller is answering 0x01 polls
// ---------------------------------------------------------------------------
module joybus_frame_sniffer #(
    parameter int CNT_W           = 8,
    parameter int VIRT_NEGEDGE_TH = 32,
    parameter int MAX_BYTES       = 10
) (
    input  logic                   CTRL_CLK,
    input  logic                   CTRL_RST,
    input  logic                   CTRL_i,
    input  logic                   frame_ack_i,
    output logic                   frame_valid_o,
    output logic [7:0]             frame_cmd_o,
    output logic [4:0]             frame_len_o,
    output logic [8*MAX_BYTES-1:0] frame_data_o,
    output logic                   frame_err_o,
    output logic [7:0]             drop_cnt_o,
    output logic                   ctrl_detected_o
);

    localparam int               DATA_W  = 8 * MAX_BYTES;
    localparam int               IDX_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] TH      = CNT_W'(VIRT_NEGEDGE_TH);
    localparam logic [4:0]       MAX_LEN = 5'(MAX_BYTES);

    generate
        if (MAX_BYTES < 3 || MAX_BYTES > 16) begin : g_bad_max_bytes
            $error("joybus_frame_sniffer: MAX_BYTES must be within 3..16");
        end
`ifdef JOYBUS_GAMEID_EN
        if (MAX_BYTES < 10) begin : g_gameid_too_small
            $error("joybus_frame_sniffer: game ID command needs MAX_BYTES >= 10");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t             state, state_nxt;
    logic [2:0]         hist;
    logic [CNT_W-1:0]   wait_cnt, low_cnt;
    logic               last_pos;
    logic [7:0]         bit_cnt;
    logic [7:0]         cmd_sr;
    logic [4:0]         cur_len;
    logic [DATA_W-1:0]  data_buf;

    logic               neg_edge, pos_edge, sat, sample, sample_bit;
    logic [4:0]         lk_len;
    logic               len_ok;
    logic [7:0]         data_pos;
    logic [IDX_W-1:0]   store_idx;
    logic               start, shift_cmd, load_len, store_bit, complete, stop_err, cmd_sat;

    // Payload length per command; 0 marks a command that is not decoded.
    function automatic logic [4:0] cmd_len(input logic [7:0] cmd);
        case (cmd)
            8'h00, 8'hFF: cmd_len = 5'd3;
            8'h01:        cmd_len = 5'd4;
`ifdef JOYBUS_GAMEID_EN
            8'h1D:        cmd_len = 5'd10;
`endif
            default:      cmd_len = 5'd0;
        endcase
    endfunction

    assign neg_edge   = hist[2] & ~hist[1];
    assign pos_edge   = ~hist[2] & hist[1];
    assign sat        = (wait_cnt == '1);
    // A bit is sampled at the next falling edge, or at a virtual falling
    // edge when the line stays high after the bit (end of frame).
    assign sample     = (neg_edge && (wait_cnt < TH)) || (last_pos && (wait_cnt == TH));
    // Short low phase followed by a long high phase encodes a 1.
    assign sample_bit = (low_cnt < wait_cnt);
    assign lk_len     = cmd_len(cmd_sr);
    assign len_ok     = (lk_len != 5'd0) && (lk_len <= MAX_LEN);
    // The first data bit is sampled while still in CMD; it is data bit 0.
    assign data_pos   = (state == S_DATA) ? bit_cnt : 8'd0;
    // Bit i of the stream lands at byte i/8, bit 7-(i%8): that is i ^ 7.
    assign store_idx  = IDX_W'(data_pos ^ 8'd7);

    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt = state;
        start     = 1'b0;
        shift_cmd = 1'b0;
        load_len  = 1'b0;
        store_bit = 1'b0;
        complete  = 1'b0;
        stop_err  = 1'b0;
        cmd_sat   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (neg_edge && sat) begin
                    state_nxt = S_CMD;
                    start     = 1'b1;
                end
            end
            S_CMD: begin
                if (sat) begin
                    state_nxt = S_IDLE;
                    cmd_sat   = 1'b1;
                end else if (sample) begin
                    if (bit_cnt < 8'd8) begin
                        shift_cmd = 1'b1;
                    end else if (len_ok) begin
                        state_nxt = S_DATA;
                        load_len  = 1'b1;
                        store_bit = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sat) begin
                    state_nxt = S_IDLE;
                end else if (sample) begin
                    if (bit_cnt < {cur_len, 3'b000}) begin
                        store_bit = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        complete  = sample_bit;
                        stop_err  = ~sample_bit;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line conditioning, interval timing and frame capture.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the values from before this clock edge.
    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            hist     <= 3'b111;
            wait_cnt <= '0;
            low_cnt  <= '0;
            last_pos <= 1'b0;
            bit_cnt  <= '0;
            cmd_sr   <= '0;
            cur_len  <= '0;
            // NOTE: the capture buffer is reset too; it is a plain register
            // (not RAM) and its zero bytes become the output padding.
            data_buf <= '0;
        end else begin
            hist <= {hist[1:0], CTRL_i};
            if (neg_edge || pos_edge) wait_cnt <= '0;
            else if (!sat)            wait_cnt <= wait_cnt + 1'b1;
            if (pos_edge) begin
                low_cnt  <= wait_cnt;
                last_pos <= 1'b1;
            end else if (neg_edge) begin
                last_pos <= 1'b0;
            end
            if (start) begin
                bit_cnt  <= '0;
                cmd_sr   <= '0;
                data_buf <= '0;
            end
            if (shift_cmd) begin
                cmd_sr  <= {cmd_sr[6:0], sample_bit};
                bit_cnt <= bit_cnt + 8'd1;
            end
            if (load_len) cur_len <= lk_len;
            if (store_bit) begin
                data_buf[store_idx] <= sample_bit;
                bit_cnt             <= data_pos + 8'd1;
            end
        end
    end

    // Held output register, drop accounting and controller presence.
    always_ff @(posedge CTRL_CLK) begin
        if (CTRL_RST) begin
            frame_valid_o   <= 1'b0;
            frame_cmd_o     <= '0;
            frame_len_o     <= '0;
            frame_data_o    <= '0;
            frame_err_o     <= 1'b0;
            drop_cnt_o      <= '0;
            ctrl_detected_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (complete) begin
                // An ack in the same cycle frees the register for the new frame.
                if (!frame_valid_o || frame_ack_i) begin
                    frame_valid_o <= 1'b1;
                    frame_cmd_o   <= cmd_sr;
                    frame_len_o   <= cur_len;
                    frame_data_o  <= data_buf;
                end else if (drop_cnt_o != 8'hFF) begin
                    drop_cnt_o <= drop_cnt_o + 8'd1;
                end
                if (cmd_sr == 8'h01) ctrl_detected_o <= 1'b1;
            end else if (frame_ack_i) begin
                frame_valid_o <= 1'b0;
            end
            if (stop_err) begin
                frame_err_o <= 1'b1;
                if (cmd_sr == 8'h01) ctrl_detected_o <= 1'b0;
            end
            if (cmd_sat) ctrl_detected_o <= 1'b0;
        end
    end

endmodule
